// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner with 2-bit BHT / JAL prediction, JALR wait and a one-entry issue register.
// Delivers one instruction per cycle on cache hits and redirects on RoB flush.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BHT_BIT  = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic [31:0] pc,
    output logic        inst_req,
    input  logic        inst_ready,
    input  logic [31:0] inst_res,
    input  logic        issue_stall,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
    output logic        issue_pred_taken,
    input  logic        br_upd_valid,
    input  logic [31:0] br_upd_pc,
    input  logic        br_upd_taken,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        rob_clear,
    input  logic [31:0] clear_pc
);
    localparam int BHT_N = 1 << BHT_BIT;

    logic [31:0] pc_q, pc_d, inst_q, inst_d, ipc_q, ipc_d;
    logic        valid_q, valid_d, pred_q, pred_d, jw_q, jw_d;
    logic [1:0]  bht_q [BHT_N];

    logic [BHT_BIT-1:0] rd_idx, up_idx;
    logic [1:0]         up_cur, up_nxt;
    logic [6:0]         opc;
    logic [31:0]        imm_j, imm_b, next_pc;
    logic               is_jal, is_br, is_jalr, br_taken, pred;
    logic               consumed, can_load;
    logic               unused_ok;

    assign rd_idx   = pc_q[BHT_BIT+1:2];
    assign up_idx   = br_upd_pc[BHT_BIT+1:2];
    assign opc      = inst_res[6:0];
    assign imm_j    = {{11{inst_res[31]}}, inst_res[31], inst_res[19:12], inst_res[20], inst_res[30:21], 1'b0};
    assign imm_b    = {{19{inst_res[31]}}, inst_res[31], inst_res[7], inst_res[30:25], inst_res[11:8], 1'b0};
    assign is_jal   = opc == 7'b1101111;
    assign is_br    = opc == 7'b1100011;
    assign is_jalr  = opc == 7'b1100111;
    assign br_taken = is_br && bht_q[rd_idx][1];
    assign pred     = is_jal || br_taken;
    assign next_pc  = is_jal ? pc_q + imm_j : br_taken ? pc_q + imm_b : pc_q + 32'd4;
    assign consumed = valid_q && !issue_stall;
    assign can_load = !valid_q || consumed;

    // Saturating 2-bit counter step for the committed branch.
    assign up_cur = bht_q[up_idx];
    assign up_nxt = br_upd_taken ? (up_cur == 2'b11 ? up_cur : up_cur + 2'd1)
                                 : (up_cur == 2'b00 ? up_cur : up_cur - 2'd1);

    assign unused_ok = ^{br_upd_pc[31:BHT_BIT+2], br_upd_pc[1:0]};

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        pred_d  = pred_q;
        jw_d    = jw_q;
        if (rob_clear) begin
            pc_d    = clear_pc;
            valid_d = 1'b0;
            jw_d    = 1'b0;
        end else if (jw_q) begin
            if (jalr_valid) begin
                pc_d = jalr_target;
                jw_d = 1'b0;
            end
            if (consumed) valid_d = 1'b0;
        end else if (inst_ready && can_load) begin
            inst_d  = inst_res;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pred_d  = pred;
            // JALR target is unknown here; pc parks until the RoB resolves it.
            pc_d    = is_jalr ? pc_q : next_pc;
            jw_d    = is_jalr;
        end else if (consumed) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            ipc_q   <= 32'h0;
            pred_q  <= 1'b0;
            jw_q    <= 1'b0;
        end else if (rdy_in) begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            pred_q  <= pred_d;
            jw_q    <= jw_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (rdy_in && br_upd_valid) begin
            bht_q[up_idx] <= up_nxt;
        end
    end

    assign pc               = pc_q;
    assign inst_req         = !jw_q;
    assign issue_valid      = valid_q;
    assign issue_inst       = inst_q;
    assign issue_pc         = ipc_q;
    assign issue_pred_taken = pred_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench for the fetch stage with a small always-hit instruction memory.
module tb_inst_fetch_unit;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [31:0] pc;
    logic        inst_req, inst_ready;
    logic [31:0] inst_res;
    logic        issue_stall, issue_valid;
    logic [31:0] issue_inst, issue_pc;
    logic        issue_pred_taken;
    logic        br_upd_valid, br_upd_taken, jalr_valid, rob_clear;
    logic [31:0] br_upd_pc, jalr_target, clear_pc;

    logic        mem_en;
    logic [31:0] imem [256];
    int          n_chk = 0;
    int          n_pass = 0;

    localparam logic [31:0] ADDI = 32'h00000013;
    localparam logic [31:0] BEQ  = 32'h02000063;
    localparam logic [31:0] JAL  = 32'hFC1FF06F;
    localparam logic [31:0] JALR = 32'h00008067;

    always #5 clk_in = ~clk_in;

    assign inst_ready = mem_en;
    assign inst_res   = imem[pc[9:2]];

    inst_fetch_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pc(pc), .inst_req(inst_req), .inst_ready(inst_ready), .inst_res(inst_res),
        .issue_stall(issue_stall), .issue_valid(issue_valid), .issue_inst(issue_inst),
        .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .br_upd_valid(br_upd_valid), .br_upd_pc(br_upd_pc), .br_upd_taken(br_upd_taken),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target),
        .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = ADDI;
        imem[4]  = BEQ;
        imem[16] = JAL;
        imem[20] = JALR;
        rst_in = 1'b1; rdy_in = 1'b1; mem_en = 1'b0; issue_stall = 1'b0;
        br_upd_valid = 1'b0; br_upd_pc = 32'h0; br_upd_taken = 1'b0;
        jalr_valid = 1'b0; jalr_target = 32'h0; rob_clear = 1'b0; clear_pc = 32'h0;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(issue_valid), 32'h0);
        check("rst_inst", issue_inst, 32'h0);
        check("rst_ipc", issue_pc, 32'h0);
        check("rst_pred", 32'(issue_pred_taken), 32'h0);
        check("rst_req", 32'(inst_req), 32'h1);

        rst_in = 1'b0; mem_en = 1'b1;
        tick();
        check("s0_valid", 32'(issue_valid), 32'h1);
        check("s0_ipc", issue_pc, 32'h0);
        check("s0_inst", issue_inst, ADDI);
        check("s0_pred", 32'(issue_pred_taken), 32'h0);
        check("s0_pc", pc, 32'h4);
        tick();
        check("s1_ipc", issue_pc, 32'h4);
        check("s1_pc", pc, 32'h8);

        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ipc", issue_pc, 32'h4);
            check("hold_inst", issue_inst, ADDI);
            check("hold_valid", 32'(issue_valid), 32'h1);
            check("hold_pc", pc, 32'h8);
        end
        issue_stall = 1'b0;
        tick();
        check("rel_ipc", issue_pc, 32'h8);
        check("rel_pc", pc, 32'hC);
        tick();
        check("s3_ipc", issue_pc, 32'hC);
        tick();
        check("beq_cold_ipc", issue_pc, 32'h10);
        check("beq_cold_inst", issue_inst, BEQ);
        check("beq_cold_pred", 32'(issue_pred_taken), 32'h0);
        check("beq_cold_pc", pc, 32'h14);

        // 01 -> 10 -> 11 -> 11 (saturate) -> 10: still predicts taken
        mem_en = 1'b0; br_upd_valid = 1'b1; br_upd_pc = 32'h10; br_upd_taken = 1'b1;
        tick();
        check("miss_drain", 32'(issue_valid), 32'h0);
        tick(); tick();
        br_upd_taken = 1'b0;
        tick();
        check("miss_pc", pc, 32'h14);
        br_upd_valid = 1'b0; rob_clear = 1'b1; clear_pc = 32'h10;
        tick();
        check("clr_pc", pc, 32'h10);
        check("clr_valid", 32'(issue_valid), 32'h0);
        rob_clear = 1'b0; mem_en = 1'b1;
        tick();
        check("beq_hot_ipc", issue_pc, 32'h10);
        check("beq_hot_pred", 32'(issue_pred_taken), 32'h1);
        check("beq_hot_pc", pc, 32'h30);

        rob_clear = 1'b1; clear_pc = 32'h40;
        tick();
        check("jal_clr_valid", 32'(issue_valid), 32'h0);
        rob_clear = 1'b0;
        tick();
        check("jal_ipc", issue_pc, 32'h40);
        check("jal_pred", 32'(issue_pred_taken), 32'h1);
        check("jal_pc", pc, 32'h0);
        tick();
        check("jal_tgt_ipc", issue_pc, 32'h0);
        check("jal_tgt_pred", 32'(issue_pred_taken), 32'h0);
        check("jal_tgt_pc", pc, 32'h4);

        rob_clear = 1'b1; clear_pc = 32'h50;
        tick();
        rob_clear = 1'b0;
        tick();
        check("jalr_ipc", issue_pc, 32'h50);
        check("jalr_inst", issue_inst, JALR);
        check("jalr_pred", 32'(issue_pred_taken), 32'h0);
        check("jalr_req", 32'(inst_req), 32'h0);
        check("jalr_pc", pc, 32'h50);
        tick();
        check("jalr_wait_valid", 32'(issue_valid), 32'h0);
        check("jalr_wait_req", 32'(inst_req), 32'h0);
        check("jalr_wait_pc", pc, 32'h50);
        jalr_valid = 1'b1; jalr_target = 32'h100;
        tick();
        check("jalr_res_pc", pc, 32'h100);
        check("jalr_res_req", 32'(inst_req), 32'h1);
        check("jalr_res_valid", 32'(issue_valid), 32'h0);
        jalr_valid = 1'b0;
        tick();
        check("jalr_tgt_ipc", issue_pc, 32'h100);
        check("jalr_tgt_pc", pc, 32'h104);

        rob_clear = 1'b1; clear_pc = 32'h50;
        tick();
        rob_clear = 1'b0;
        tick();
        check("fl_pre_valid", 32'(issue_valid), 32'h1);
        check("fl_pre_req", 32'(inst_req), 32'h0);
        issue_stall = 1'b1; rob_clear = 1'b1; clear_pc = 32'h200;
        tick();
        check("fl_valid", 32'(issue_valid), 32'h0);
        check("fl_req", 32'(inst_req), 32'h1);
        check("fl_pc", pc, 32'h200);
        rob_clear = 1'b0; issue_stall = 1'b0;
        tick();
        check("fl_ipc", issue_pc, 32'h200);
        check("fl_next_pc", pc, 32'h204);

        rdy_in = 1'b0;
        tick();
        check("rdy_pc", pc, 32'h204);
        check("rdy_ipc", issue_pc, 32'h200);
        rdy_in = 1'b1;
        tick();
        check("rdy_resume_ipc", issue_pc, 32'h204);
        check("rdy_resume_pc", pc, 32'h208);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
